// File: rtl/hamming_ecc_pkg.sv
// Shared definitions for the Hamming(7,4) byte encoder: FSM state type,
// codeword geometry and the nibble encoding function.
package hamming_ecc_pkg;

   localparam int unsigned CW_W      = 7;
   localparam int unsigned DATA_W    = 4;
   localparam int unsigned P_HI_IDX  = 6;
   localparam int unsigned P_MID_IDX = 5;
   localparam int unsigned P_LO_IDX  = 3;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FIRST,
      ST_SECOND
   } enc_state_t;

   // Data bits sit at 4,2,1,0; parity bits at 6,5,3 so that each parity
   // group XORs to zero over its covered positions.
   function automatic logic [CW_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] c;
      c            = '0;
      c[4]         = d[3];
      c[2]         = d[2];
      c[1]         = d[1];
      c[0]         = d[0];
      c[P_HI_IDX]  = d[3] ^ d[2] ^ d[0];
      c[P_MID_IDX] = d[3] ^ d[1] ^ d[0];
      c[P_LO_IDX]  = d[2] ^ d[1] ^ d[0];
      return c;
   endfunction

endpackage

// File: rtl/hamming_ecc_nibble_encoder.sv
// Combinational 4-to-7 Hamming encoder around the package function.
module hamming_ecc_nibble_encoder
   import hamming_ecc_pkg::*;
(
   input  logic [DATA_W-1:0] nibble,
   output logic [CW_W-1:0]   codeword
);

   // Pure encode, no state.
   always_comb begin
      codeword = hamming_encode(nibble);
   end

endmodule

// File: rtl/hamming_ecc_byte_encoder.sv
// Byte-to-codeword encoder: takes a byte per input handshake and emits two
// Hamming(7,4) codewords, one per output handshake, plus a handshake counter.
// Optional build macro HAMMING_ERR_INJECT_EN adds inj_en/inj_pos ports that
// flip one bit of a codeword at the moment it is loaded.
module hamming_ecc_byte_encoder
   import hamming_ecc_pkg::*;
#(
   parameter int unsigned LOW_NIBBLE_FIRST = 1,
   parameter int unsigned COUNT_W          = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   output logic               cw_valid,
   input  logic               cw_ready,
   output logic [CW_W-1:0]    cw_data,
   output logic               cw_last,
   output logic [COUNT_W-1:0] cw_count
`ifdef HAMMING_ERR_INJECT_EN
   ,
   input  logic               inj_en,
   input  logic [2:0]         inj_pos
`endif
);

   enc_state_t        state;
   logic [7:0]        held;
   logic [DATA_W-1:0] nib_sel;
   logic [CW_W-1:0]   enc_cw;
   logic [CW_W-1:0]   inj_mask;
   logic [CW_W-1:0]   load_cw;

   function automatic logic [DATA_W-1:0] first_nib(input logic [7:0] b);
      return (LOW_NIBBLE_FIRST != 0) ? b[3:0] : b[7:4];
   endfunction

   function automatic logic [DATA_W-1:0] second_nib(input logic [7:0] b);
      return (LOW_NIBBLE_FIRST != 0) ? b[7:4] : b[3:0];
   endfunction

   // One shared encoder: in FIRST the next load is the held byte's second
   // nibble; in every other state a load can only come from a new input byte.
   always_comb begin
      nib_sel = (state == ST_FIRST) ? second_nib(held) : first_nib(in_data);
   end

   hamming_ecc_nibble_encoder u_enc (
      .nibble   (nib_sel),
      .codeword (enc_cw)
   );

   // Error-injection mask; a shift of 7 falls off the 7-bit word, so
   // inj_pos=7 naturally injects nothing.
   always_comb begin
      inj_mask = '0;
`ifdef HAMMING_ERR_INJECT_EN
      if (inj_en) inj_mask = CW_W'(7'd1 << inj_pos);
`endif
      load_cw = enc_cw ^ inj_mask;
   end

   // Combinational accept: empty, or finishing the second codeword this cycle.
   always_comb begin
      in_ready = !rst && ((state == ST_EMPTY) || ((state == ST_SECOND) && cw_ready));
   end

   always_comb begin
      cw_valid = (state != ST_EMPTY);
      cw_last  = (state == ST_SECOND);
   end

   // FSM, held byte, output codeword register and handshake counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         held     <= '0;
         cw_data  <= '0;
         cw_count <= '0;
      end else begin
         if (cw_valid && cw_ready) cw_count <= cw_count + COUNT_W'(1);
         unique case (state)
            ST_EMPTY: begin
               if (in_valid) begin
                  held    <= in_data;
                  cw_data <= load_cw;
                  state   <= ST_FIRST;
               end
            end
            ST_FIRST: begin
               if (cw_ready) begin
                  cw_data <= load_cw;
                  state   <= ST_SECOND;
               end
            end
            ST_SECOND: begin
               if (cw_ready) begin
                  if (in_valid) begin
                     held    <= in_data;
                     cw_data <= load_cw;
                     state   <= ST_FIRST;
                  end else begin
                     state   <= ST_EMPTY;
                  end
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_ecc_byte_encoder.sv
// Scoreboard bench for hamming_ecc_byte_encoder. Two instances share the
// stimulus: one low-nibble-first with a 16-bit counter, one high-nibble-first
// with a 3-bit counter so the wrap is exercised.
module tb_hamming_ecc_byte_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        cw_ready;
   logic        inj_en = 1'b0;
   logic [2:0]  inj_pos = 3'd7;

   logic        in_ready_a, cw_valid_a, cw_last_a;
   logic [6:0]  cw_data_a;
   logic [15:0] cw_count_a;
   logic        in_ready_b, cw_valid_b, cw_last_b;
   logic [6:0]  cw_data_b;
   logic [2:0]  cw_count_b;

   typedef struct {
      logic [6:0] cw_a;
      logic [6:0] cw_b;
      logic       last;
   } exp_t;

   exp_t        q[$];
   logic [15:0] cnt = '0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          rand_rdy = 1'b0;

   always #5 clk = ~clk;

   hamming_ecc_byte_encoder #(.LOW_NIBBLE_FIRST(1), .COUNT_W(16)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .cw_valid(cw_valid_a), .cw_ready(cw_ready),
      .cw_data(cw_data_a), .cw_last(cw_last_a), .cw_count(cw_count_a)
`ifdef HAMMING_ERR_INJECT_EN
      , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
   );

   hamming_ecc_byte_encoder #(.LOW_NIBBLE_FIRST(0), .COUNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .cw_valid(cw_valid_b), .cw_ready(cw_ready),
      .cw_data(cw_data_b), .cw_last(cw_last_b), .cw_count(cw_count_b)
`ifdef HAMMING_ERR_INJECT_EN
      , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder built from generator rows (linear superposition).
   function automatic logic [6:0] ref_enc(input logic [3:0] d);
      logic [6:0] c;
      c = '0;
      if (d[0]) c ^= 7'h69;
      if (d[1]) c ^= 7'h2A;
      if (d[2]) c ^= 7'h4C;
      if (d[3]) c ^= 7'h70;
      return c;
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      return {c[6] ^ c[4] ^ c[2] ^ c[0], c[5] ^ c[4] ^ c[1] ^ c[0], c[3] ^ c[2] ^ c[1] ^ c[0]};
   endfunction

   function automatic logic [6:0] model_inj();
      logic [6:0] m;
      m = '0;
`ifdef HAMMING_ERR_INJECT_EN
      if (inj_en && inj_pos != 3'd7) m[inj_pos] = 1'b1;
`endif
      return m;
   endfunction

   // Monitor: outputs are sampled mid-cycle; the handshakes seen here are the
   // ones the next rising edge will complete.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check_eq("in_ready_rst_a", 32'(in_ready_a), 0);
         check_eq("in_ready_rst_b", 32'(in_ready_b), 0);
         q.delete();
         cnt = '0;
      end else begin
         check_eq("cw_valid_a", 32'(cw_valid_a), 32'(q.size() != 0));
         check_eq("cw_valid_b", 32'(cw_valid_b), 32'(q.size() != 0));
         check_eq("in_ready_a", 32'(in_ready_a), 32'(q.size() == 0 || (q.size() == 1 && cw_ready)));
         check_eq("in_ready_b", 32'(in_ready_b), 32'(q.size() == 0 || (q.size() == 1 && cw_ready)));
         check_eq("cw_count_a", 32'(cw_count_a), 32'(cnt));
         check_eq("cw_count_b", 32'(cw_count_b), 32'(cnt[2:0]));
         if (q.size() != 0) begin
            e = q[0];
            check_eq("cw_data_a", 32'(cw_data_a), 32'(e.cw_a));
            check_eq("cw_data_b", 32'(cw_data_b), 32'(e.cw_b));
            check_eq("cw_last_a", 32'(cw_last_a), 32'(e.last));
            check_eq("cw_last_b", 32'(cw_last_b), 32'(e.last));
            if (!inj_en) check_eq("syndrome_a", 32'(syndrome(cw_data_a)), 0);
            if (cw_ready) begin
               void'(q.pop_front());
               cnt = cnt + 16'd1;
            end
         end
         if (in_valid && in_ready_a) begin
            e.cw_a = ref_enc(in_data[3:0]) ^ model_inj();
            e.cw_b = ref_enc(in_data[7:4]) ^ model_inj();
            e.last = 1'b0;
            q.push_back(e);
            e.cw_a = ref_enc(in_data[7:4]) ^ model_inj();
            e.cw_b = ref_enc(in_data[3:0]) ^ model_inj();
            e.last = 1'b1;
            q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) cw_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic put_byte(input logic [7:0] b);
      bit hs;
      hs = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 200 && !hs; i++) begin
         @(negedge clk);
         hs = in_ready_a;
         step();
      end
      if (!hs) check_eq("in_handshake_timeout", 0, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      cw_ready = 1'b1;
      for (int i = 0; i < 100 && q.size() != 0; i++) step();
      check_eq("drain_empty", 32'(q.size()), 0);
      step();
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      cw_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Single byte, always ready
      cw_ready = 1'b1;
      put_byte(8'h81);
      drain();

      // Back-to-back bytes with no bubble
      put_byte(8'h00);
      put_byte(8'hFF);
      drain();

      // Output stall during FIRST
      cw_ready = 1'b0;
      put_byte(8'h18);
      in_valid = 1'b0;
      repeat (5) step();
      drain();

      // Reset while in SECOND
      cw_ready = 1'b0;
      put_byte(8'h81);
      in_valid = 1'b0;
      cw_ready = 1'b1;
      step();
      cw_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      cw_ready = 1'b1;
      put_byte(8'h3C);
      drain();

      // All byte values with random output backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            in_valid = 1'b0;
            step();
         end
         put_byte(8'(i));
      end
      drain();

`ifdef HAMMING_ERR_INJECT_EN
      inj_en  = 1'b1;
      inj_pos = 3'd3;
      put_byte(8'h00);
      drain();
      inj_pos = 3'd7;
      put_byte(8'h00);
      drain();
      inj_en = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hamming_ecc_byte_encoder.md
# hamming_ecc_byte_encoder

Upstream stage of the Hamming(7,4) decoder. Accepts bytes over a valid/ready stream, splits each byte into two nibbles, encodes each nibble into a 7-bit Hamming codeword and presents the codewords one per handshake on a registered valid/ready output. The output feeds the codeword input of the decoder, possibly through a channel or FIFO. A free-running codeword counter supports link monitoring.

## Interface

- `LOW_NIBBLE_FIRST`, 1: 1 sends `in_data[3:0]` first; 0 sends `in_data[7:4]` first.
- `COUNT_W`, 16: width of the codeword counter.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_data`  in  8  byte to encode.
- `cw_valid`  out  1  codeword valid.
- `cw_ready`  in  1  downstream accepts when `cw_valid && cw_ready`.
- `cw_data`  out  7  codeword.
- `cw_last`  out  1  high on the second codeword of a byte.
- `cw_count`  out  `COUNT_W`  number of codeword handshakes completed, modulo 2^`COUNT_W`.
- `inj_en`, `inj_pos[2:0]`  in  present only with `HAMMING_ERR_INJECT_EN` (see Configuration).

## Operation

- Encoding of nibble d[3:0]:
  - data bits: c4=d3, c2=d2, c1=d1, c0=d0.
  - parity bits: c6=d3^d2^d0, c5=d3^d1^d0, c3=d2^d1^d0.
  - Property: c6^c4^c2^c0 = c5^c4^c1^c0 = c3^c2^c1^c0 = 0.
- FSM states:
  - EMPTY: `cw_valid`=0.
  - FIRST: presenting the first codeword of the held byte.
  - SECOND: presenting the second codeword.
- `cw_valid` = (state != EMPTY). `cw_last` = (state == SECOND).
- `in_ready` = !rst && (state==EMPTY || (state==SECOND && cw_ready)). This is combinational.
- Transitions:
  - EMPTY, input handshake: latch byte; load `cw_data` with enc(first nibble); go to FIRST.
  - FIRST, `cw_ready`: load enc(second nibble) from the held byte; go to SECOND. No `cw_ready`: hold.
  - SECOND, `cw_ready` and `in_valid`: latch the new byte; load its first codeword; go to FIRST. This is a simultaneous output and input handshake with no bubble.
  - SECOND, `cw_ready` without `in_valid`: go to EMPTY.
  - SECOND, no `cw_ready`: hold.
- `cw_data` and `cw_last` are stable while `cw_valid && !cw_ready`.
- `cw_count` increments by 1 on every output handshake and wraps from all-ones to 0.

## Timing

- Reset: state EMPTY, `cw_valid`=0, `cw_last`=0, `cw_data`=0, `cw_count`=0, held byte=0, `in_ready`=0 while `rst` is high.
- Reset mid-byte: the pending codeword(s) are discarded. There is no output handshake in the reset cycle.
- Latency: the first codeword is valid on the cycle after the input handshake.
- Throughput: 1 byte per 2 cycles with `cw_ready` held high. `cw_valid` stays high continuously under back-to-back input.
- Input stall: `in_ready` is low in FIRST, and in SECOND while `cw_ready` is low.

## Configuration

- `HAMMING_ERR_INJECT_EN` defined:
  - Adds ports `inj_en` (in, 1) and `inj_pos` (in, 3).
  - When a codeword is loaded into `cw_data` while `inj_en`=1 and `inj_pos`<7, bit `inj_pos` of that codeword is inverted.
  - `inj_pos`=7 injects nothing.
  - Sampling happens at load time only. Changing `inj_en` or `inj_pos` while a codeword is held does not alter it.
- Not defined: the ports are absent and codewords are always clean.

## Structure

- Package `hamming_ecc_pkg`: FSM state enum, codeword/data width constants (7, 4), parity bit indices (6, 5, 3), function `hamming_encode(logic [3:0]) -> logic [6:0]`.
- Sub-module `hamming_ecc_nibble_encoder`: combinational 4→7 encoder wrapping the package function. Instantiate it once, fed by a nibble mux (first/second nibble).

## Test plan

- Reset, then `in_data`=8'h81 with `cw_ready`=1, `LOW_NIBBLE_FIRST`=1 → `cw_data`=7'h69 (`cw_last`=0), then 7'h70 (`cw_last`=1); `cw_count`=2.
- Bytes 8'h00 and 8'hFF back-to-back with `cw_ready`=1 → 7'h00, 7'h00, 7'h7F, 7'h7F on four consecutive cycles; `in_ready` high in the SECOND-state cycles.
- Stall: hold `cw_ready`=0 for 5 cycles during FIRST with byte 8'h18 (`LOW_NIBBLE_FIRST`=0) → `cw_data` holds 7'h69 and `in_ready`=0; after release, 7'h70 follows.
- Exhaustive: all 256 bytes with random `cw_ready` → every codeword has all three parity checks equal to 0, and re-assembled nibbles match the input order.
- Assert `rst` while in SECOND → next cycle `cw_valid`=0, `cw_count`=0; the next byte starts a fresh FIRST codeword.
- With `HAMMING_ERR_INJECT_EN`, byte 8'h00, `inj_en`=1, `inj_pos`=3 → both codewords 7'h08; with `inj_pos`=7 → 7'h00.
